// File: rtl/bcd_conv_arbiter.sv
// Two-port binary-to-BCD converter: arbitrates between two requesters, then runs a 9-step
// shift-and-add-3 conversion. Define BCD_RR_ARB_EN for round-robin ties (default: port 0 wins).
module bcd_conv_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [8:0]  din0,
    output logic        ack0,
    input  logic        req1,
    input  logic [8:0]  din1,
    output logic        ack1,
    output logic [11:0] bcd_out,
    output logic        done,
    output logic        done_id,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]  state;
    logic [8:0]  sreg;
    logic [11:0] acc;
    logic [3:0]  cnt;
    logic        owner;
    logic        gnt0;
    logic        gnt1;
    logic [11:0] acc_adj;
    logic [11:0] acc_next;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

`ifdef BCD_RR_ARB_EN
    logic last_gnt; // port granted most recently; the other port wins a tie

    always_comb begin
        gnt0 = req0 & (~req1 | last_gnt);
        gnt1 = req1 & (~req0 | ~last_gnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (state == ST_IDLE && (gnt0 || gnt1)) begin
            last_gnt <= gnt1;
        end
    end
`else
    always_comb begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
    end
`endif

    // All three digits are corrected from their pre-shift values, then shifted together.
    always_comb begin
        acc_adj  = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
        acc_next = {acc_adj[10:0], sreg[8]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sreg    <= '0;
            acc     <= '0;
            cnt     <= '0;
            owner   <= 1'b0;
            bcd_out <= '0;
            done    <= 1'b0;
            done_id <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        sreg  <= gnt0 ? din0 : din1;
                        acc   <= '0;
                        cnt   <= '0;
                        owner <= gnt1;
                        ack0  <= gnt0;
                        ack1  <= gnt1;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                default: begin
                    acc  <= acc_next;
                    sreg <= {sreg[7:0], 1'b0};
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd8) begin
                        bcd_out <= acc_next;
                        done_id <= owner;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed and random conversions checked against
// decimal arithmetic and a simple grant-history model; follows BCD_RR_ARB_EN like the design.
module tb_bcd_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [8:0]  din0, din1;
    logic        ack0, ack1;
    logic [11:0] bcd_out;
    logic        done, done_id, busy;

    int checks = 0;
    int errors = 0;
    int last_grant = 1;

`ifdef BCD_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    bcd_conv_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .din0    (din0),
        .ack0    (ack0),
        .req1    (req1),
        .din1    (din1),
        .ack1    (ack1),
        .bcd_out (bcd_out),
        .done    (done),
        .done_id (done_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int tie_winner();
        if (!RR) return 0;
        return (last_grant == 0) ? 1 : 0;
    endfunction

    task automatic start(input int port, input logic [8:0] v);
        if (port == 0) begin req0 = 1'b1; din0 = v; end
        else begin req1 = 1'b1; din1 = v; end
    endtask

    // Expects the grant on the very next edge; optionally withdraws the winner's request.
    task automatic wait_ack(input int port, input bit drop);
        int n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin n = i; break; end
        end
        chk("ack_latency", 32'(n), 32'd1);
        chk("ack0", 32'(ack0), 32'(port == 0));
        chk("ack1", 32'(ack1), 32'(port == 1));
        chk("busy_at_ack", 32'(busy), 32'd1);
        last_grant = port;
        if (drop) begin
            if (port == 0) req0 = 1'b0;
            else req1 = 1'b0;
        end
    endtask

    task automatic wait_done(input int port, input int v, input bit intrude);
        int n = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (intrude && i == 2) begin req1 = 1'b1; din1 = 9'($urandom_range(0, 511)); end
            if (intrude && i == 6) req1 = 1'b0;
            chk("ack_pulse", 32'(ack0 | ack1), 32'd0);
            if (done) begin n = i; break; end
        end
        chk("done_latency", 32'(n), 32'd9);
        chk("bcd_out", 32'(bcd_out), 32'(ref_bcd(v)));
        chk("digit_range", 32'(bcd_out[11:8] <= 4'd9 && bcd_out[7:4] <= 4'd9 &&
                               bcd_out[3:0] <= 4'd9), 32'd1);
        chk("done_id", 32'(done_id), 32'(port));
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic convert(input int port, input logic [8:0] v);
        start(port, v);
        wait_ack(port, 1'b1);
        wait_done(port, int'(v), 1'b0);
    endtask

    initial begin
        int w;
        int v0;
        int v1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;
        #1;
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_acks", 32'({ack0, ack1}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        convert(0, 9'd255);
        convert(1, 9'd0);
        convert(1, 9'd511);

        // Both ports hold requests continuously.
        start(0, 9'd123);
        start(1, 9'd456);
        for (int k = 0; k < 3; k++) begin
            w = tie_winner();
            wait_ack(w, 1'b0);
            wait_done(w, (w == 0) ? 123 : 456, 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Abort mid-conversion with an asynchronous reset.
        start(0, 9'd99);
        wait_ack(0, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_bcd", 32'(bcd_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done_id", 32'(done_id), 32'd0);
        last_grant = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_quiet", 32'({done, busy}), 32'd0);
        end
        convert(0, 9'd9);

        // Port 1 requests while busy and withdraws before the block is free.
        start(0, 9'($urandom_range(0, 511)));
        v0 = int'(din0);
        wait_ack(0, 1'b1);
        wait_done(0, v0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("withdrawn_quiet", 32'({ack1, done, busy}), 32'd0);
        end

        // Random simultaneous requests: winner first, loser served right after.
        for (int k = 0; k < 20; k++) begin
            v0 = int'($urandom_range(0, 511));
            v1 = int'($urandom_range(0, 511));
            start(0, 9'(v0));
            start(1, 9'(v1));
            w = tie_winner();
            wait_ack(w, 1'b1);
            wait_done(w, (w == 0) ? v0 : v1, 1'b0);
            wait_ack(1 - w, 1'b1);
            wait_done(1 - w, (w == 0) ? v1 : v0, 1'b0);
        end

        for (int k = 0; k < 30; k++) begin
            convert(int'($urandom_range(0, 1)), 9'($urandom_range(0, 511)));
        end

        for (int v = 0; v < 512; v++) begin
            convert(0, 9'(v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 Parameters: none; input width fixed at 9 bits, output fixed at 12 bits (3 BCD digits).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0  input  1  port-0 conversion request; level, held until ack0.
REQ-005 din0  input  9  port-0 binary operand, 0..511.
REQ-006 ack0  output  1  one-cycle pulse: port-0 operand accepted.
REQ-007 req1  input  1  port-1 conversion request; level, held until ack1.
REQ-008 din1  input  9  port-1 binary operand, 0..511.
REQ-009 ack1  output  1  one-cycle pulse: port-1 operand accepted.
REQ-010 bcd_out  output  12  result; [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-011 done  output  1  one-cycle pulse: bcd_out updated this cycle.
REQ-012 done_id  output  1  port that owns the current bcd_out (0/1).
REQ-013 busy  output  1  high while a conversion is in progress.

Function
REQ-014 FSM states: IDLE, SHIFT; the block SHALL hold one conversion at a time.
REQ-015 IDLE: at a rising edge with req0 or req1 high, arbitrate (REQ-022/026), latch the winner's din into a 9-bit shift register, clear the 12-bit BCD accumulator, clear the bit counter, go to SHIFT.
REQ-016 Acceptance edge: ack of the winner high for exactly the following cycle; busy high from that edge.
REQ-017 SHIFT, per edge: each BCD digit >= 5 gets +3 (all three digits checked in parallel on pre-shift values), then accumulator shifted left 1 with the shift-register MSB entering bit 0; shift register shifted left 1; counter +1.
REQ-018 On the 9th SHIFT edge: load bcd_out with the final accumulator, set done_id to the owner, pulse done for one cycle, clear busy, return to IDLE.
REQ-019 Latency: done high exactly 9 cycles after the ack cycle begins (acceptance edge + 9 edges); throughput one conversion per 10 cycles.
REQ-020 A new request SHALL be accepted on the edge that ends the done cycle (back-to-back allowed).
REQ-021 Requests arriving while busy SHALL be ignored until IDLE; din sampled only at the acceptance edge; bcd_out and done_id hold between done pulses.
REQ-022 Only one of ack0/ack1 SHALL be high in any cycle; ack never asserted without matching req at the acceptance edge.
REQ-023 A req dropped before ack SHALL be treated as withdrawn; no conversion starts for it.
REQ-024 Every 9-bit input SHALL yield the exact decimal digits (e.g. 511 -> 0x511); no digit ever exceeds 9.

Reset
REQ-025 rst high: state IDLE, counter 0, bcd_out 0x000, done 0, done_id 0, ack0 0, ack1 0, busy 0, last-grant pointer 1 (port 0 wins the first tie); a conversion in progress SHALL be aborted with no done pulse.

Configuration
REQ-026 Macro BCD_RR_ARB_EN defined: round-robin; on simultaneous requests grant the port not granted last, and update the last-grant pointer on every grant.
REQ-027 BCD_RR_ARB_EN undefined: fixed priority, port 0 always wins ties; pointer logic absent.

Verification
REQ-028 req0=1, din0=255, req1=0 -> ack0 one cycle; 9 cycles later done=1, bcd_out=0x255, done_id=0, busy low.
REQ-029 din1=0 then din1=511 back-to-back on port 1 -> bcd_out 0x000 then 0x511, done_id=1, second ack1 on edge ending first done cycle.
REQ-030 req0 and req1 held high, din0=123, din1=456, BCD_RR_ARB_EN defined -> results alternate 0x123(id0), 0x456(id1), 0x123(id0); undefined -> port 0 only, port 1 starved.
REQ-031 Start din0=99, assert rst 4 cycles after ack0 -> all outputs zero immediately, no done; after release, req0 din0=9 -> 0x009.
REQ-032 Sweep din0 0..511 -> every bcd_out matches the reference decimal digits; digits always <= 9.
REQ-033 req1 asserted while busy then dropped before IDLE -> no ack1, no conversion for port 1.
